vec_lsu: RTL and testbench

- Vector load/store sequencer directly upstream of the data memory.
- Accepts one 4-lane strided memory request from execute and generates lane addresses base + i*stride.
- Drives the memory's scalar port (we/a/wd) and vector port (wev/va/wdv), captures load data, and returns a registered response to writeback.
- Fully-enabled, collision-free, in-range stores use one vector write cycle. All other stores are serialized lane by lane on the scalar port.

---
 rtl/vec_lsu.sv | 195 +++++++++++++++++++
 tb/tb_vec_lsu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lsu.sv
// vec_lsu: 4-lane strided vector load/store sequencer in front of the data memory.
// Takes one request at a time, forms lane addresses base + i*stride, and issues
// them to memory. Loads, and stores that can complete in one vector write, use
// the vector port for one cycle. Every other store goes out lane by lane on the
// scalar port. The response is held until it is taken.
//
// State | meaning
// IDLE  | waiting for a request; req_ready = 1
// ACC   | one vector access (vector write, or load capture)
// SER   | scalar store of lane k_q, one lane per cycle, k_q = 0..3
// RESP  | response presented; held until resp_ready
//
// Ports:
//   clk, reset (async, active-low)
//   req_*  : request from execute (valid/ready, store, base, stride, mask, wdata[0:3])
//   resp_* : response to writeback (valid/ready, rdata[0:3], err)
//   mem_we/mem_a/mem_wd      : scalar write port
//   mem_wev/mem_va/mem_wdv   : vector write port and read addresses
//   mem_rdv                  : combinational vector read data
module vec_lsu #(
  parameter int MEM_DEPTH = 1001,
  parameter int LANES     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [31:0] req_base,
  input  logic [31:0] req_stride,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata [0:3],
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata [0:3],
  output logic [3:0]  resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_wev,
  output logic [31:0] mem_va [0:3],
  output logic [31:0] mem_wdv [0:3],
  input  logic [31:0] mem_rdv [0:3]
);

  typedef enum logic [1:0] {IDLE, ACC, SER, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        store_q, store_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  inr_q, inr_d;
  logic [31:0] addr_q  [0:3];
  logic [31:0] addr_d  [0:3];
  logic [31:0] wdata_q [0:3];
  logic [31:0] wdata_d [0:3];
  logic [31:0] rdata_q [0:3];
  logic [31:0] rdata_d [0:3];

  // Lane addresses and range flags for the request currently on the inputs.
  logic [31:0] new_addr [0:3];
  logic [3:0]  new_inr;
  logic        new_distinct;
  logic        new_fast;
  logic        accept;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      new_addr[i] = req_base + req_stride * 32'(i);
      new_inr[i]  = (new_addr[i] <= 32'(MEM_DEPTH - 1));
    end
    new_distinct = (new_addr[0] != new_addr[1]) && (new_addr[0] != new_addr[2]) &&
                   (new_addr[0] != new_addr[3]) && (new_addr[1] != new_addr[2]) &&
                   (new_addr[1] != new_addr[3]) && (new_addr[2] != new_addr[3]);
    new_fast     = (req_mask == 4'hF) && (new_inr == 4'hF) && new_distinct;
  end

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    store_d = store_q;
    mask_d  = mask_q;
    inr_d   = inr_q;
    for (int i = 0; i < LANES; i++) begin
      addr_d[i]  = addr_q[i];
      wdata_d[i] = wdata_q[i];
      rdata_d[i] = rdata_q[i];
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          store_d = req_store;
          mask_d  = req_mask;
          inr_d   = new_inr;
          k_d     = 2'd0;
          for (int i = 0; i < LANES; i++) begin
            addr_d[i]  = new_addr[i];
            wdata_d[i] = req_wdata[i];
            rdata_d[i] = 32'h0;
          end
          state_d = (!req_store || new_fast) ? ACC : SER;
        end
      end
      ACC: begin
        if (!store_q) begin
          for (int i = 0; i < LANES; i++) begin
            rdata_d[i] = (mask_q[i] && inr_q[i]) ? mem_rdv[i] : 32'h0;
          end
        end
        state_d = RESP;
      end
      SER: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      store_q <= 1'b0;
      mask_q  <= 4'h0;
      inr_q   <= 4'h0;
      for (int i = 0; i < LANES; i++) begin
        addr_q[i]  <= 32'h0;
        wdata_q[i] <= 32'h0;
        rdata_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      store_q <= store_d;
      mask_q  <= mask_d;
      inr_q   <= inr_d;
      for (int i = 0; i < LANES; i++) begin
        addr_q[i]  <= addr_d[i];
        wdata_q[i] <= wdata_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  // Outputs decode from registered state only; out-of-range lanes present
  // address 0 so a bad address can never reach memory.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = 4'h0;
    mem_we     = 1'b0;
    mem_a      = 32'h0;
    mem_wd     = 32'h0;
    mem_wev    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      resp_rdata[i] = 32'h0;
      mem_va[i]     = 32'h0;
      mem_wdv[i]    = 32'h0;
    end

    case (state_q)
      ACC: begin
        mem_wev = store_q;
        for (int i = 0; i < LANES; i++) begin
          mem_va[i]  = inr_q[i] ? addr_q[i] : 32'h0;
          mem_wdv[i] = store_q ? wdata_q[i] : 32'h0;
        end
      end
      SER: begin
        mem_we = mask_q[k_q] && inr_q[k_q];
        mem_a  = inr_q[k_q] ? addr_q[k_q] : 32'h0;
        mem_wd = wdata_q[k_q];
      end
      RESP: begin
        resp_err = mask_q & ~inr_q;
        for (int i = 0; i < LANES; i++) begin
          resp_rdata[i] = rdata_q[i];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_lsu.sv
module tb_vec_lsu;

  localparam int DEPTH = 1001;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [31:0] req_base;
  logic [31:0] req_stride;
  logic [3:0]  req_mask;
  logic [31:0] req_wdata [0:3];
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata [0:3];
  logic [3:0]  resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_wev;
  logic [31:0] mem_va [0:3];
  logic [31:0] mem_wdv [0:3];
  logic [31:0] mem_rdv [0:3];

  vec_lsu #(.MEM_DEPTH(DEPTH), .LANES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_mask(req_mask),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_wev(mem_wev), .mem_va(mem_va), .mem_wdv(mem_wdv), .mem_rdv(mem_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT, and a reference copy updated by the model.
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] mem_ref [0:DEPTH-1];

  always_comb begin
    for (int i = 0; i < 4; i++)
      mem_rdv[i] = (mem_va[i] < 32'(DEPTH)) ? mem[mem_va[i][9:0]] : 32'h0;
  end

  int we_cnt, wev_cnt, bad_cnt;

  always @(posedge clk) begin
    if (mem_wev) begin
      wev_cnt <= wev_cnt + 1;
      for (int i = 0; i < 4; i++) begin
        if (mem_va[i] < 32'(DEPTH)) mem[mem_va[i][9:0]] <= mem_wdv[i];
        else bad_cnt <= bad_cnt + 1;
      end
    end
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_a < 32'(DEPTH)) mem[mem_a[9:0]] <= mem_wd;
      else bad_cnt <= bad_cnt + 1;
    end
    if (mem_we && mem_wev) bad_cnt <= bad_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [127:0] pack_rdata();
    return {resp_rdata[3], resp_rdata[2], resp_rdata[1], resp_rdata[0]};
  endfunction

  task automatic check_reset_outputs(input string name);
    logic ok;
    ok = req_ready && !resp_valid && (resp_err == 4'h0) && !mem_we && !mem_wev &&
         (mem_a == 32'h0) && (mem_wd == 32'h0);
    for (int i = 0; i < 4; i++)
      ok = ok && (resp_rdata[i] == 32'h0) && (mem_va[i] == 32'h0) && (mem_wdv[i] == 32'h0);
    check(name, {127'h0, ok}, 128'h1);
  endtask

  typedef struct {
    logic             st;
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [3:0]       mask;
    logic [3:0][31:0] wd;
    int               delay;
    logic [3:0]       exp_err;
    int               exp_lat;
  } vec_t;

  // One request end to end. Expected values come from the model below, which
  // works from the lane address rule with plain 64-bit arithmetic; table
  // entries additionally carry hand-computed err/latency.
  task automatic do_req(input string tag, input logic st, input logic [31:0] base,
                        input logic [31:0] stride, input logic [3:0] mask,
                        input logic [3:0][31:0] wd, input int delay, input logic hold,
                        input logic use_tbl, input logic [3:0] tbl_err, input int tbl_lat);
    logic [31:0]  a [4];
    logic [3:0]   inr, err;
    logic         fast;
    logic [127:0] exp_rd, snap_rd;
    logic [3:0]   snap_err;
    int           exp_we, exp_wev, exp_lat, lat, busy_ready, unstable, diffs;

    for (int i = 0; i < 4; i++) begin
      a[i]   = 32'((64'(base) + 64'(i) * 64'(stride)) % 64'h1_0000_0000);
      inr[i] = (a[i] < 32'(DEPTH));
    end
    err  = mask & ~inr;
    fast = (mask == 4'hF) && (inr == 4'hF);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (a[i] == a[j]) fast = 1'b0;
    exp_rd = '0;
    exp_we = 0;
    exp_wev = 0;
    if (!st) begin
      for (int i = 0; i < 4; i++)
        if (mask[i] && inr[i]) exp_rd[32*i +: 32] = mem_ref[a[i][9:0]];
      exp_lat = 2;
    end else if (fast) begin
      exp_wev = 1;
      exp_lat = 2;
    end else begin
      exp_lat = 5;
    end
    if (st) begin
      for (int i = 0; i < 4; i++)
        if (mask[i] && inr[i]) begin
          mem_ref[a[i][9:0]] = wd[i];
          if (!fast) exp_we++;
        end
    end
    if (use_tbl) begin
      check({tag, " tbl_err"}, {124'h0, err}, {124'h0, tbl_err});
      check({tag, " tbl_lat"}, 128'(exp_lat), 128'(tbl_lat));
    end

    @(negedge clk);
    we_cnt = 0;
    wev_cnt = 0;
    bad_cnt = 0;
    req_valid = 1'b1;
    req_store = st;
    req_base = base;
    req_stride = stride;
    req_mask = mask;
    for (int i = 0; i < 4; i++) req_wdata[i] = wd[i];
    check({tag, " req_ready idle"}, {127'h0, req_ready}, 128'h1);
    @(posedge clk);
    lat = 1;
    busy_ready = 0;
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    if (req_ready) busy_ready++;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (req_ready) busy_ready++;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " rdata"}, pack_rdata(), exp_rd);
    check({tag, " err"}, {124'h0, resp_err}, {124'h0, err});

    snap_rd = pack_rdata();
    snap_err = resp_err;
    unstable = 0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (!resp_valid || pack_rdata() != snap_rd || resp_err != snap_err) unstable++;
      if (req_ready) busy_ready++;
    end
    if (delay > 0) check({tag, " resp stable"}, 128'(unstable), 128'h0);
    check({tag, " req_ready busy"}, 128'(busy_ready), 128'h0);

    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
    check({tag, " post handshake"}, {126'h0, resp_valid, req_ready}, 128'h1);

    check({tag, " we pulses"}, 128'(we_cnt), 128'(exp_we));
    check({tag, " wev pulses"}, 128'(wev_cnt), 128'(exp_wev));
    check({tag, " bad mem access"}, 128'(bad_cnt), 128'h0);
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== mem_ref[i]) diffs++;
    check({tag, " memory"}, 128'(diffs), 128'h0);
  endtask

  vec_t vecs [$];

  initial begin
    logic [3:0][31:0] wd;
    int sel;
    logic [31:0] b, s;
    logic [3:0] m;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'h5A00_0000 + 32'(i);
      mem_ref[i] = 32'h5A00_0000 + 32'(i);
    end
    mem[10] = 32'hA; mem[11] = 32'hB; mem[12] = 32'hC; mem[13] = 32'hD;
    mem_ref[10] = 32'hA; mem_ref[11] = 32'hB; mem_ref[12] = 32'hC; mem_ref[13] = 32'hD;

    vecs.push_back('{1'b0, 32'd10,  32'd1,        4'hF, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 4'h0, 2});
    vecs.push_back('{1'b1, 32'd20,  32'd2,        4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, 1, 4'h0, 2});
    vecs.push_back('{1'b1, 32'd5,   32'd0,        4'hF, {32'd6, 32'd9, 32'd8, 32'd7}, 0, 4'h0, 5});
    vecs.push_back('{1'b1, 32'd998, 32'd1,        4'hF, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 4'h8, 5});
    vecs.push_back('{1'b0, 32'd0,   32'hFFFF_FFFF, 4'h5, {32'h0, 32'h0, 32'h0, 32'h0}, 2, 4'h4, 2});
    vecs.push_back('{1'b1, 32'd30,  32'd1,        4'h0, {32'h1, 32'h2, 32'h3, 32'h4}, 0, 4'h0, 5});
    vecs.push_back('{1'b0, 32'd30,  32'd1,        4'h0, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 4'h0, 2});
    vecs.push_back('{1'b0, 32'd5,   32'd0,        4'hF, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 4'h0, 2});
    vecs.push_back('{1'b1, 32'd500, 32'hFFFF_FFFD, 4'hF, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 0, 4'h0, 2});
    vecs.push_back('{1'b1, 32'd100, 32'd4,        4'hE, {32'h9, 32'h8, 32'h7, 32'h6}, 0, 4'h0, 5});
    vecs.push_back('{1'b0, 32'd20,  32'd2,        4'hF, {32'h0, 32'h0, 32'h0, 32'h0}, 0, 4'h0, 2});

    reset = 1'b0;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_base = 32'h0;
    req_stride = 32'h0;
    req_mask = 4'h0;
    for (int i = 0; i < 4; i++) req_wdata[i] = 32'h0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset values");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle after reset");

    foreach (vecs[n])
      do_req($sformatf("vec%0d", n), vecs[n].st, vecs[n].base, vecs[n].stride, vecs[n].mask,
             vecs[n].wd, vecs[n].delay, 1'b0, 1'b1, vecs[n].exp_err, vecs[n].exp_lat);

    // Response held 3 cycles while another request waits on req_valid.
    do_req("hold", 1'b0, 32'd10, 32'd1, 4'hF, '0, 3, 1'b1, 1'b1, 4'h0, 2);

    // Reset during serialized store, lane 1 active: lane 0 already written.
    @(negedge clk);
    we_cnt = 0;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_base = 32'd60;
    req_stride = 32'd1;
    req_mask = 4'h7;
    req_wdata[0] = 32'h11; req_wdata[1] = 32'h22; req_wdata[2] = 32'h33; req_wdata[3] = 32'h44;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort lane1 we", {127'h0, mem_we}, 128'h1);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort reset values");
    mem_ref[60] = 32'h11;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort mem60", 128'(mem[60]), 128'(mem_ref[60]));
    check("abort mem61", 128'(mem[61]), 128'(mem_ref[61]));
    check("abort we count", 128'(we_cnt), 128'h1);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: b = 32'($urandom_range(0, 1000));
        1: b = 32'($urandom_range(990, 1010));
        2: b = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: b = 32'($urandom_range(0, 30));
      endcase
      sel = $urandom_range(0, 5);
      case (sel)
        0: s = 32'h0;
        1: s = 32'h1;
        2: s = 32'hFFFF_FFFF;
        3: s = 32'($urandom_range(0, 300));
        4: s = 32'h0 - 32'($urandom_range(1, 300));
        default: s = $urandom();
      endcase
      m = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) wd[i] = $urandom();
      do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), b, s, m, wd,
             $urandom_range(0, 2), 1'b0, 1'b0, 4'h0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
